// File: rtl/fifo_pkg.sv
// Shared read-mode constants and the pointer-wrap helper for the parameterised FIFO.
// Used by the FIFO top and its testbench; holds no logic of its own.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Depth need not be a power of two, so wrap explicitly at depth-1.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DWIDTH array, synchronous write, asynchronous read, no reset.
// Write lands on the rising edge; read data follows raddr combinationally.
module fifo_mem #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO, any depth >= 2, standard (1-cycle registered read) or FWFT read mode.
// Push while full is accepted only alongside a real pop; rejected push/pop set sticky error flags.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 4,
    parameter int DEPTH  = 16,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              pop,
    output logic [DWIDTH-1:0] out,
    output logic              empty,
    output logic              almostempty,
    output logic              full,
    output logic              almostfull,
    output logic [AWIDTH:0]   num,
    input  logic [AWIDTH:0]   ae_thresh,
    input  logic [AWIDTH:0]   af_thresh,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    generate
        if (DEPTH < 2 || DEPTH > (1 << AWIDTH)) begin : g_bad_depth
            $error("param_sync_fifo: DEPTH must be in 2..2**AWIDTH");
        end
    endgenerate

    localparam logic [AWIDTH:0] L_DEPTH = (AWIDTH + 1)'(DEPTH);

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_num;
    logic [DWIDTH-1:0] r_out;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_pop_ok;
    logic              w_push_ok;
    logic [DWIDTH-1:0] w_rdata;

    assign w_empty   = (r_num == '0);
    assign w_full    = (r_num == L_DEPTH);
    assign w_pop_ok  = pop & ~w_empty;
    // A pop frees the slot this push needs, so full does not block it.
    assign w_push_ok = push & (~w_full | w_pop_ok);

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (w_push_ok),
        .waddr  (r_wr_ptr),
        .wdata  (data_in),
        .raddr  (r_rd_ptr),
        .rdata  (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_num       <= '0;
            r_out       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= AWIDTH'(ptr_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_pop_ok) begin
                r_rd_ptr <= AWIDTH'(ptr_inc(32'(r_rd_ptr), DEPTH));
                r_out    <= w_rdata;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_num <= r_num + 1'b1;
                2'b01:   r_num <= r_num - 1'b1;
                default: r_num <= r_num;
            endcase
            // A fresh error in the clearing cycle wins over clr_err.
            r_overflow  <= (r_overflow  & ~clr_err) | (push & ~w_push_ok);
            r_underflow <= (r_underflow & ~clr_err) | (pop & w_empty);
        end
    end

    assign out         = (FWFT == FIFO_MODE_FWFT) ? (w_empty ? '0 : w_rdata) : r_out;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almostempty = (r_num <= ae_thresh);
    assign almostfull  = (r_num >= af_thresh);
    assign num         = r_num;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: three instances (depth 16 std, depth 12 std, depth 16 FWFT)
// share stimulus; a queue scoreboard holds expected read data.
module tb_param_sync_fifo;

    logic        clk;
    logic        rst_n;
    logic        push;
    logic        pop;
    logic        clr_err;
    logic [15:0] din;
    logic [4:0]  ae;
    logic [4:0]  af;

    logic [15:0] a_out, b_out, c_out;
    logic        a_empty, a_ae, a_full, a_af, a_ovf, a_unf;
    logic        b_empty, b_ae, b_full, b_af, b_ovf, b_unf;
    logic        c_empty, c_ae, c_full, c_af, c_ovf, c_unf;
    logic [4:0]  a_num, b_num, c_num;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] q[$];
    logic [15:0] exp_d;
    int          mnum, sent, rcv, cyc;
    logic        do_push, do_pop;

    param_sync_fifo #(.DWIDTH(16), .AWIDTH(4), .DEPTH(16), .FWFT(0)) u_a (
        .clk(clk), .reset(rst_n), .push(push), .data_in(din), .pop(pop), .out(a_out),
        .empty(a_empty), .almostempty(a_ae), .full(a_full), .almostfull(a_af), .num(a_num),
        .ae_thresh(ae), .af_thresh(af), .overflow(a_ovf), .underflow(a_unf), .clr_err(clr_err)
    );

    param_sync_fifo #(.DWIDTH(16), .AWIDTH(4), .DEPTH(12), .FWFT(0)) u_b (
        .clk(clk), .reset(rst_n), .push(push), .data_in(din), .pop(pop), .out(b_out),
        .empty(b_empty), .almostempty(b_ae), .full(b_full), .almostfull(b_af), .num(b_num),
        .ae_thresh(ae), .af_thresh(af), .overflow(b_ovf), .underflow(b_unf), .clr_err(clr_err)
    );

    param_sync_fifo #(.DWIDTH(16), .AWIDTH(4), .DEPTH(16), .FWFT(1)) u_c (
        .clk(clk), .reset(rst_n), .push(push), .data_in(din), .pop(pop), .out(c_out),
        .empty(c_empty), .almostempty(c_ae), .full(c_full), .almostfull(c_af), .num(c_num),
        .ae_thresh(ae), .af_thresh(af), .overflow(c_ovf), .underflow(c_unf), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
        step();
        step();
        rst_n = 1'b1;
        q.delete();
    endtask

    initial begin
        ae = 5'd2;
        af = 5'd14;
        do_reset();

        // Reset state
        chk("rst_num",   32'(a_num),   0);
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_full",  32'(a_full),  0);
        chk("rst_ae",    32'(a_ae),    1);
        chk("rst_af",    32'(a_af),    0);
        chk("rst_out",   32'(a_out),   0);
        chk("rst_ovf",   32'(a_ovf),   0);
        chk("rst_unf",   32'(a_unf),   0);

        // Fill to full, then one overflowing push
        push = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            din = 16'(i);
            q.push_back(din);
            step();
            chk("fill_num",  32'(a_num),  32'(i));
            chk("fill_af",   32'(a_af),   32'(i >= 14));
            chk("fill_full", 32'(a_full), 32'(i == 16));
            chk("fill_ae",   32'(a_ae),   32'(i <= 2));
        end
        din = 16'h0099;
        step();
        chk("ovf_set", 32'(a_ovf), 1);
        chk("ovf_num", 32'(a_num), 16);
        push = 1'b0;

        // Drain in order, then one underflowing pop
        pop = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            exp_d = q.pop_front();
            step();
            chk("drain_out", 32'(a_out), 32'(exp_d));
            chk("drain_num", 32'(a_num), 32'(i));
            chk("drain_ae",  32'(a_ae),  32'(i <= 2));
        end
        step();
        chk("unf_set",   32'(a_unf),   1);
        chk("unf_hold",  32'(a_out),   32'h0010);
        chk("unf_empty", 32'(a_empty), 1);
        pop = 1'b0;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_ovf", 32'(a_ovf), 0);
        chk("clr_unf", 32'(a_unf), 0);

        // Full with simultaneous push and pop
        push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 16'h0100 + 16'(i);
            q.push_back(din);
            step();
        end
        pop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din = 16'h0200 + 16'(k);
            q.push_back(din);
            exp_d = q.pop_front();
            step();
            chk("pp_out",  32'(a_out),  32'(exp_d));
            chk("pp_num",  32'(a_num),  16);
            chk("pp_full", 32'(a_full), 1);
            chk("pp_ovf",  32'(a_ovf),  0);
        end
        push = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_d = q.pop_front();
            step();
            chk("pp_drain", 32'(a_out), 32'(exp_d));
        end
        chk("pp_empty", 32'(a_empty), 1);
        push = 1'b1;
        din  = 16'h0333;
        step();
        push = 1'b0; pop = 1'b0;
        chk("epp_num", 32'(a_num), 1);
        chk("epp_unf", 32'(a_unf), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr2_ovf", 32'(a_ovf), 0);
        chk("clr2_unf", 32'(a_unf), 0);

        // Depth-12 wrap with random gaps
        do_reset();
        mnum = 0; sent = 0; rcv = 0; cyc = 0;
        while (rcv < 40 && cyc < 2000) begin
            do_push = (sent < 40) && (mnum < 12) && ($urandom_range(0, 1) == 1);
            do_pop  = (mnum > 0) && ($urandom_range(0, 1) == 1);
            push = do_push;
            pop  = do_pop;
            din  = sent[15:0];
            if (do_push) begin
                q.push_back(din);
                sent++;
            end
            if (do_pop) exp_d = q.pop_front();
            step();
            if (do_pop) begin
                chk("wrap_out", 32'(b_out), 32'(exp_d));
                rcv++;
            end
            mnum = mnum + int'(do_push) - int'(do_pop);
            chk("wrap_num", 32'(b_num), 32'(mnum));
            cyc++;
        end
        push = 1'b0; pop = 1'b0;
        chk("wrap_done", 32'(rcv), 40);
        chk("wrap_ovf", 32'(b_ovf), 0);
        chk("wrap_unf", 32'(b_unf), 0);

        // FWFT head visibility
        do_reset();
        push = 1'b1;
        din  = 16'hBEEF;
        step();
        push = 1'b0;
        chk("fwft_out",   32'(c_out),   32'hBEEF);
        chk("fwft_empty", 32'(c_empty), 0);
        step();
        chk("fwft_hold", 32'(c_out), 32'hBEEF);
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("fwft_pop_out",   32'(c_out),   0);
        chk("fwft_pop_empty", 32'(c_empty), 1);

        // Asynchronous reset mid-stream
        do_reset();
        push = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            din = 16'h0700 + 16'(i);
            step();
        end
        push = 1'b0;
        pop  = 1'b1;
        step();
        pop  = 1'b0;
        chk("pre_rst_num", 32'(a_num), 7);
        chk("pre_rst_out", 32'(a_out), 32'h0701);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_num",   32'(a_num),   0);
        chk("arst_empty", 32'(a_empty), 1);
        chk("arst_out",   32'(a_out),   0);
        chk("arst_full",  32'(a_full),  0);
        chk("arst_ovf",   32'(a_ovf),   0);
        chk("arst_unf",   32'(a_unf),   0);
        @(negedge clk);
        rst_n = 1'b1;
        push  = 1'b1;
        din   = 16'hCAFE;
        step();
        push = 1'b0;
        pop  = 1'b1;
        step();
        pop  = 1'b0;
        chk("post_rst_out",   32'(a_out),   32'hCAFE);
        chk("post_rst_empty", 32'(a_empty), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
